// File: rtl/clk_rst_seq.sv
// Reset sequencer plus CH_NUM clock-enable dividers (IDLE->DLY->HOLD->RUN->DONE).
// Define CLK_RST_SEQ_PHASE_EN to preload each divider counter from PH_I at RUN entry.
module clk_rst_seq #(
    parameter int CH_NUM   = 4,
    parameter int DIV_W    = 8,
    parameter int RST_DLY  = 10,
    parameter int RST_HOLD = 10,
    parameter int TIMEOUT  = 40,
    parameter int CYC_W    = 16
) (
    input  logic                      CLK_I,
    input  logic                      nRST_I,
    input  logic                      EN_I,
    input  logic [CH_NUM*DIV_W-1:0]   DIV_I,
    input  logic [CH_NUM*DIV_W-1:0]   PH_I,
    output logic                      nRST_O,
    output logic                      RUN_O,
    output logic                      DONE_O,
    output logic [CH_NUM-1:0]         CE_O,
    output logic [CH_NUM-1:0]         TGL_O,
    output logic [CYC_W-1:0]          CYC_O
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DLY  = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int MAX_SEQ = (RST_DLY > RST_HOLD) ? RST_DLY : RST_HOLD;
    localparam int SEQ_W   = $clog2(MAX_SEQ + 1);

    localparam logic [SEQ_W-1:0] SEQ_ONE   = SEQ_W'(1);
    localparam logic [SEQ_W-1:0] DLY_LAST  = SEQ_W'(RST_DLY - 1);
    localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(RST_HOLD - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]                   state_q, state_d;
    logic [SEQ_W-1:0]             seq_q, seq_d;
    logic                         nrst_q, nrst_d;
    logic                         run_q, run_d;
    logic                         done_q, done_d;
    logic [CYC_W-1:0]             cyc_q, cyc_d;
    logic [CH_NUM-1:0]            ce_q, ce_d;
    logic [CH_NUM-1:0]            tgl_q, tgl_d;
    logic [CH_NUM-1:0][DIV_W-1:0] div_q, div_d;
    logic [CH_NUM-1:0][DIV_W-1:0] cnt_q, cnt_d;

    // Per-channel divisor and counter preload values captured at RUN entry.
    logic [CH_NUM-1:0][DIV_W-1:0] ld_div;
    logic [CH_NUM-1:0][DIV_W-1:0] ld_cnt;

`ifndef CLK_RST_SEQ_PHASE_EN
    logic unused_ph;
    assign unused_ph = ^PH_I;
`endif

    always_comb begin
        ld_div = '0;
        ld_cnt = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            ld_div[n] = DIV_I[n*DIV_W +: DIV_W];
            if (ld_div[n] == '0) begin
                ld_div[n] = DIV_ONE;
            end
`ifdef CLK_RST_SEQ_PHASE_EN
            ld_cnt[n] = PH_I[n*DIV_W +: DIV_W];
            if (ld_cnt[n] >= ld_div[n]) begin
                ld_cnt[n] = ld_div[n] - DIV_ONE;
            end
`endif
        end
    end

    // NOTE: every _d gets a default first so no path through the case leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        nrst_d  = nrst_q;
        run_d   = run_q;
        done_d  = done_q;
        cyc_d   = cyc_q;
        ce_d    = '0;
        tgl_d   = tgl_q;
        div_d   = div_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (EN_I) begin
                    state_d = ST_DLY;
                    seq_d   = '0;
                end
            end
            ST_DLY: begin
                if (seq_q == DLY_LAST) begin
                    state_d = ST_HOLD;
                    seq_d   = '0;
                    nrst_d  = 1'b0;
                end else begin
                    seq_d = seq_q + SEQ_ONE;
                end
            end
            ST_HOLD: begin
                if (seq_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    seq_d   = '0;
                    nrst_d  = 1'b1;
                    run_d   = 1'b1;
                    cyc_d   = '0;
                    div_d   = ld_div;
                    cnt_d   = ld_cnt;
                    for (int n = 0; n < CH_NUM; n++) begin
                        ce_d[n] = (ld_cnt[n] == ld_div[n] - DIV_ONE);
                    end
                end else begin
                    seq_d = seq_q + SEQ_ONE;
                end
            end
            ST_RUN: begin
                if ((TIMEOUT > 0) && (cyc_q == CYC_LAST)) begin
                    state_d = ST_DONE;
                    run_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                    // ce_q marks the cycle whose counter sat at D-1, so it also selects the wrap.
                    for (int n = 0; n < CH_NUM; n++) begin
                        cnt_d[n] = ce_q[n] ? '0 : cnt_q[n] + DIV_ONE;
                        ce_d[n]  = (cnt_d[n] == div_q[n] - DIV_ONE);
                        tgl_d[n] = tgl_q[n] ^ ce_q[n];
                    end
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping EN_I anywhere outside IDLE aborts straight back to the idle values.
        if ((state_q != ST_IDLE) && !EN_I) begin
            state_d = ST_IDLE;
            seq_d   = '0;
            nrst_d  = 1'b1;
            run_d   = 1'b0;
            done_d  = 1'b0;
            cyc_d   = '0;
            ce_d    = '0;
            tgl_d   = '0;
            div_d   = '0;
            cnt_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK_I) begin
        if (!nRST_I) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            nrst_q  <= 1'b1;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
            ce_q    <= '0;
            tgl_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            nrst_q  <= nrst_d;
            run_q   <= run_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
            ce_q    <= ce_d;
            tgl_q   <= tgl_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    assign nRST_O = nrst_q;
    assign RUN_O  = run_q;
    assign DONE_O = done_q;
    assign CE_O   = ce_q;
    assign TGL_O  = tgl_q;
    assign CYC_O  = cyc_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq: two instances (TIMEOUT=40 and TIMEOUT=0 with a short CYC_W)
// compared each cycle against a model computed from elapsed edges since the start of a sequence.
module tb_clk_rst_seq;

    localparam int CH   = 4;
    localparam int DW   = 8;
    localparam int RD   = 10;
    localparam int RH   = 10;
    localparam int TO_A = 40;
    localparam int CW_A = 16;
    localparam int TO_B = 0;
    localparam int CW_B = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              en;
    logic [CH*DW-1:0]  div;
    logic [CH*DW-1:0]  ph;

    logic              a_nrst, a_run, a_done;
    logic [CH-1:0]     a_ce, a_tgl;
    logic [CW_A-1:0]   a_cyc;
    logic              b_nrst, b_run, b_done;
    logic [CH-1:0]     b_ce, b_tgl;
    logic [CW_B-1:0]   b_cyc;

    clk_rst_seq #(.CH_NUM(CH), .DIV_W(DW), .RST_DLY(RD), .RST_HOLD(RH),
                  .TIMEOUT(TO_A), .CYC_W(CW_A)) u_dut_a (
        .CLK_I(clk), .nRST_I(rst_n), .EN_I(en), .DIV_I(div), .PH_I(ph),
        .nRST_O(a_nrst), .RUN_O(a_run), .DONE_O(a_done),
        .CE_O(a_ce), .TGL_O(a_tgl), .CYC_O(a_cyc)
    );

    clk_rst_seq #(.CH_NUM(CH), .DIV_W(DW), .RST_DLY(RD), .RST_HOLD(RH),
                  .TIMEOUT(TO_B), .CYC_W(CW_B)) u_dut_b (
        .CLK_I(clk), .nRST_I(rst_n), .EN_I(en), .DIV_I(div), .PH_I(ph),
        .nRST_O(b_nrst), .RUN_O(b_run), .DONE_O(b_done),
        .CE_O(b_ce), .TGL_O(b_tgl), .CYC_O(b_cyc)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Model: whether a sequence is active, edges since it started, and the values latched at RUN entry.
    bit active = 1'b0;
    int t = 0;
    int md[CH];
    int mp[CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_out(input int to, input int cw,
                                      output logic nrst, output logic run, output logic done,
                                      output logic [CH-1:0] ce, output logic [CH-1:0] tgl,
                                      output int cyc);
        int r;
        nrst = 1'b1; run = 1'b0; done = 1'b0; ce = '0; tgl = '0; cyc = 0;
        if (active) begin
            if (t >= RD && t < RD + RH) begin
                nrst = 1'b0;
            end else if (t >= RD + RH) begin
                r = t - RD - RH + 1;
                if (to > 0 && r > to) begin
                    done = 1'b1;
                    cyc  = to - 1;
                    for (int n = 0; n < CH; n++) tgl[n] = (((to - 1 + mp[n]) / md[n]) % 2) == 1;
                end else begin
                    run = 1'b1;
                    cyc = (r - 1) % (1 << cw);
                    for (int n = 0; n < CH; n++) begin
                        ce[n]  = ((r + mp[n]) % md[n]) == 0;
                        tgl[n] = (((r - 1 + mp[n]) / md[n]) % 2) == 1;
                    end
                end
            end
        end
    endfunction

    task automatic step();
        logic e_nrst, e_run, e_done;
        logic [CH-1:0] e_ce, e_tgl;
        int e_cyc;
        @(posedge clk);
        if (!rst_n) active = 1'b0;
        else if (!active) begin
            if (en) begin active = 1'b1; t = 0; end
        end else if (!en) active = 1'b0;
        else t++;
        if (active && t == RD + RH) begin
            for (int n = 0; n < CH; n++) begin
                md[n] = int'(div[n*DW +: DW]);
                if (md[n] == 0) md[n] = 1;
`ifdef CLK_RST_SEQ_PHASE_EN
                mp[n] = int'(ph[n*DW +: DW]);
                if (mp[n] >= md[n]) mp[n] = md[n] - 1;
`else
                mp[n] = 0;
`endif
            end
        end
        #1;
        model_out(TO_A, CW_A, e_nrst, e_run, e_done, e_ce, e_tgl, e_cyc);
        check("a_nrst", 32'(a_nrst), 32'(e_nrst));
        check("a_run",  32'(a_run),  32'(e_run));
        check("a_done", 32'(a_done), 32'(e_done));
        check("a_ce",   32'(a_ce),   32'(e_ce));
        check("a_tgl",  32'(a_tgl),  32'(e_tgl));
        check("a_cyc",  32'(a_cyc),  32'(e_cyc));
        model_out(TO_B, CW_B, e_nrst, e_run, e_done, e_ce, e_tgl, e_cyc);
        check("b_nrst", 32'(b_nrst), 32'(e_nrst));
        check("b_run",  32'(b_run),  32'(e_run));
        check("b_done", 32'(b_done), 32'(e_done));
        check("b_ce",   32'(b_ce),   32'(e_ce));
        check("b_tgl",  32'(b_tgl),  32'(e_tgl));
        check("b_cyc",  32'(b_cyc),  32'(e_cyc));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        div   = {8'd4, 8'd3, 8'd2, 8'd1};
        ph    = {8'd9, 8'd0, 8'd1, 8'd0};
        step();
        step();
        check("reset_nrst", 32'(a_nrst), 32'd1);
        check("reset_cyc",  32'(a_cyc),  32'd0);
        rst_n = 1'b1;
        step();

        // Full sequence into RUN and on to DONE; DIV_I changes mid-RUN must be ignored.
        en = 1'b1;
        for (int e = 0; e < 70; e++) begin
            step();
            if (e == 9)  check("t1_nrst_high_9", 32'(a_nrst), 32'd1);
            if (e == 10) check("t1_nrst_low_10", 32'(a_nrst), 32'd0);
            if (e == 19) check("t1_nrst_low_19", 32'(a_nrst), 32'd0);
            if (e == 20) check("t1_run_20",      32'(a_run),  32'd1);
            if (e == 20) check("t1_nrst_hi_20",  32'(a_nrst), 32'd1);
`ifdef CLK_RST_SEQ_PHASE_EN
            if (e == 20) check("t6_ce3_first",   32'(a_ce[3]), 32'd1);
`else
            if (e == 22) check("t1_ce3_not_yet", 32'(a_ce[3]), 32'd0);
            if (e == 23) check("t1_ce3_first",   32'(a_ce[3]), 32'd1);
`endif
            if (e == 30) div = {8'd7, 8'd7, 8'd7, 8'd7};
            if (e == 59) check("t2_run_59",      32'(a_run),  32'd1);
            if (e == 60) check("t2_done_60",     32'(a_done), 32'd1);
            if (e == 60) check("t2_cyc_60",      32'(a_cyc),  32'd39);
            if (e == 65) check("t2_ce_zero",     32'(a_ce),   32'd0);
        end

        // Abort during HOLD.
        en = 1'b0;
        step();
        en  = 1'b1;
        div = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int e = 0; e < 16; e++) step();
        en = 1'b0;
        step();
        check("t3_nrst_16", 32'(a_nrst), 32'd1);
        check("t3_run_16",  32'(a_run),  32'd0);
        repeat (25) step();

        // Synchronous reset mid-RUN with EN_I held high, then re-sequence.
        en = 1'b1;
        repeat (30) step();
        rst_n = 1'b0;
        step();
        check("t4_run_rst", 32'(a_run),  32'd0);
        check("t4_tgl_rst", 32'(a_tgl),  32'd0);
        rst_n = 1'b1;
        repeat (30) step();

        // ch0 divisor 0 acts as 1; TIMEOUT=0 instance wraps CYC_O.
        en = 1'b0;
        step();
        en  = 1'b1;
        div = {8'd4, 8'd3, 8'd2, 8'd0};
        for (int e = 0; e < RD + RH + 80; e++) begin
            step();
            if (e == RD + RH)      check("t5_ce0_first", 32'(b_ce[0]), 32'd1);
            if (e == RD + RH + 64) check("t5_cyc_wrap",  32'(b_cyc),   32'd0);
            if (e == RD + RH + 70) check("t5_no_done",   32'(b_done),  32'd0);
        end

        // Randomised rounds: random divisors/phases, sporadic EN_I drops and resets.
        for (int round = 0; round < 10; round++) begin
            en = 1'b0;
            step();
            for (int n = 0; n < CH; n++) begin
                div[n*DW +: DW] = DW'($urandom_range(0, 6));
                ph[n*DW +: DW]  = DW'($urandom_range(0, 9));
            end
            en = 1'b1;
            for (int i = 0; i < 90; i++) begin
                rst_n = ($urandom_range(0, 59) != 0);
                en    = ($urandom_range(0, 39) != 0);
                if (i == 40) div = CH*DW'($urandom);
                step();
            end
            rst_n = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
